// File: rtl/softshell_wb_initiator.sv
// Single-outstanding command/response front end driving a Wishbone classic initiator port.
// Defining SOFTSHELL_WBI_TIMEOUT_EN adds a bus-timeout abort after TIMEOUT cycles of STB.
module softshell_wb_initiator #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [3:0]  cmd_sel,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  output logic [15:0] txn_count,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e      state_q;
  logic        cmd_ready_q;
  logic        cyc_q;
  logic        stb_q;
  logic        we_q;
  logic [3:0]  sel_q;
  logic [31:0] adr_q;
  logic [31:0] dat_q;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [31:0] rsp_dat_q;
  logic [15:0] txn_cnt_q;
  logic [15:0] txn_cnt_d;
  logic [7:0]  err_cnt_q;
  logic [7:0]  err_cnt_d;
  logic        tmo_hit_s;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : (v + 8'd1);
  endfunction

  // Counter values committed when a response is consumed.
  always_comb begin
    txn_cnt_d = txn_cnt_q + 16'd1;
    if (rsp_err_q) begin
      err_cnt_d = sat_inc8(err_cnt_q);
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

`ifdef SOFTSHELL_WBI_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] tmo_q;

  assign tmo_hit_s = (tmo_q == TMO_LAST);

  // Counts BUS cycles; held at zero outside BUS so it starts from zero on entry.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      tmo_q <= 8'd0;
    end else if (state_q == S_BUS) begin
      tmo_q <= tmo_q + 8'd1;
    end else begin
      tmo_q <= 8'd0;
    end
  end
`else
  logic unused_timeout_s;
  assign unused_timeout_s = (TIMEOUT != 32'd0);
  assign tmo_hit_s        = 1'b0;
`endif

  // Transaction FSM with all outputs registered.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= 4'd0;
      adr_q       <= 32'd0;
      dat_q       <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_dat_q   <= 32'd0;
      txn_cnt_q   <= 16'd0;
      err_cnt_q   <= 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_ready_q && cmd_valid) begin
            state_q     <= S_BUS;
            cmd_ready_q <= 1'b0;
            cyc_q       <= 1'b1;
            stb_q       <= 1'b1;
            we_q        <= cmd_we;
            sel_q       <= cmd_sel;
            adr_q       <= cmd_adr;
            dat_q       <= cmd_dat;
          end
        end
        S_BUS: begin
          if (wbm_err_i || wbm_ack_i || tmo_hit_s) begin
            state_q     <= S_RESP;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
            // Error beats ack, and ack beats a timeout landing in the same cycle.
            if (wbm_err_i) begin
              rsp_err_q <= 1'b1;
              rsp_dat_q <= 32'd0;
            end else if (wbm_ack_i) begin
              rsp_err_q <= 1'b0;
              rsp_dat_q <= we_q ? 32'd0 : wbm_dat_i;
            end else begin
              rsp_err_q <= 1'b1;
              rsp_dat_q <= 32'd0;
            end
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            txn_cnt_q   <= txn_cnt_d;
            err_cnt_q   <= err_cnt_d;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          cmd_ready_q <= 1'b0;
          cyc_q       <= 1'b0;
          stb_q       <= 1'b0;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = stb_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;
  assign txn_count = txn_cnt_q;
  assign err_count = err_cnt_q;

endmodule

// File: doc/softshell_wb_initiator.md
SOFTSHELL_WB_INITIATOR -- requirements
Module: softshell_wb_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the maximum number of cycles STB stays asserted before abort (legal 2..255).
REQ-002 SHALL have port wb_clk_i, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port wb_rst_ni, input, 1, synchronous active-low reset.
REQ-004 SHALL have cmd_valid in 1 / cmd_ready out 1, the command handshake.
REQ-005 SHALL have cmd_we in 1, cmd_sel in 4, cmd_adr in 32 and cmd_dat in 32, the command fields.
REQ-006 SHALL have rsp_valid out 1 / rsp_ready in 1, the response handshake.
REQ-007 SHALL have rsp_dat out 32 (read data) and rsp_err out 1 (bus error or timeout).
REQ-008 SHALL have wbm_cyc_o, wbm_stb_o and wbm_we_o out 1, wbm_sel_o out 4, and wbm_adr_o and wbm_dat_o out 32, the Wishbone classic initiator outputs.
REQ-009 SHALL have wbm_dat_i in 32, wbm_ack_i in 1 and wbm_err_i in 1, the target responses.
REQ-010 SHALL have txn_count out 16 (completed transactions) and err_count out 8 (errored transactions).

Function
REQ-011 SHALL implement states IDLE, BUS and RESP.
REQ-012 IDLE: cmd_ready=1; on cmd_valid, SHALL register all cmd fields and enter BUS next cycle. cmd_ready SHALL be 0 in BUS and RESP.
REQ-013 BUS: wbm_cyc_o=wbm_stb_o=1, and registered we/sel/adr/dat SHALL drive the wbm outputs, stable for the whole of BUS.
REQ-014 BUS termination on wbm_ack_i: SHALL capture wbm_dat_i (reads) or 0 (writes) into rsp_dat, set rsp_err=0 and enter RESP; cyc/stb deassert the following cycle.
REQ-015 BUS termination on wbm_err_i: SHALL set rsp_err=1, rsp_dat=0 and enter RESP. If ack and err arrive together, err wins.
REQ-016 Latency: one command accepted in cycle N SHALL give stb high at N+1. A single-cycle ack at N+1 SHALL give rsp_valid at N+2.
REQ-017 RESP: rsp_valid=1 and rsp_dat/rsp_err held stable until rsp_ready=1; then SHALL return to IDLE next cycle.
REQ-018 Single outstanding transaction only: a cmd_valid asserted outside IDLE SHALL be ignored until cmd_ready.
REQ-019 txn_count SHALL increment by 1 on every RESP->IDLE transition and wrap 0xFFFF->0x0000.
REQ-020 err_count SHALL increment when rsp_err=1 at RESP exit and saturate at 0xFF.
REQ-021 wbm_ack_i and wbm_err_i seen while not in BUS SHALL be ignored.

Reset
REQ-022 With wb_rst_ni=0 at a clock edge, the block SHALL enter IDLE next cycle, with cyc/stb/we=0, sel=0, adr=0, dat=0, rsp_valid=0, rsp_dat=0, rsp_err=0, txn_count=0, err_count=0, timeout counter=0, and cmd_ready=0 while reset is asserted.
REQ-023 Reset mid-BUS or mid-RESP SHALL drop cyc/stb in the next cycle, discard the transaction, and leave the counters zeroed, with no response.

Configuration
REQ-024 Macro SOFTSHELL_WBI_TIMEOUT_EN defined: a counter SHALL clear on BUS entry and increment each BUS cycle.
REQ-025 With the macro defined, if TIMEOUT BUS cycles elapse without ack/err, the block SHALL abort: drop cyc/stb, rsp_err=1, rsp_dat=0, enter RESP. An ack in the final cycle wins over the timeout.
REQ-026 Macro undefined: no timeout counter SHALL exist, and BUS waits indefinitely for ack/err.

Verification
REQ-027 Write: cmd we=1, adr=0x3000_0004, dat=0xA5A5_5A5A, sel=0xF, ack after 3 cycles -> wbm outputs match for all BUS cycles, then rsp_valid, rsp_err=0, rsp_dat=0, txn_count=1.
REQ-028 Read: cmd we=0, adr=0x3000_0000, target acks on the first cycle with 0x1234_5678 -> rsp_valid 2 cycles after accept, rsp_dat=0x1234_5678.
REQ-029 Error: wbm_err_i and wbm_ack_i together -> rsp_err=1, rsp_dat=0, err_count=1.
REQ-030 Timeout (macro on, TIMEOUT=16): no ack -> stb high exactly 16 cycles, then rsp_err=1. Macro off: stb still high after 1000 cycles.
REQ-031 Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid/rsp_dat stable, cmd_ready=0, and a new cmd_valid is ignored.
REQ-032 Reset during BUS (cycle 2 of 4-cycle wait) -> cyc/stb=0 next cycle, no rsp_valid, counters 0, cmd_ready=1 after release.
